// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button debouncer with press/release strobes, long-hold and auto-repeat
// A level change is accepted only after DEBOUNCE_CYCLES consecutive samples agree; every output is registered.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_sync,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_hold
);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("button_debounce: DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must all be >= 2");
  end

  // Debounce and repeat counters never exceed COUNT-1; the hold counter saturates at HOLD_CYCLES.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [DB_W-1:0]   db_cnt, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_d;
  logic              level_d, press_d, release_d, repeat_d, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_hold     <= 1'b0;
    end else begin
      state         <= state_d;
      db_cnt        <= db_cnt_d;
      hold_cnt      <= hold_cnt_d;
      rep_cnt       <= rep_cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
      long_hold     <= long_d;
    end
  end

  always_comb begin
    state_d    = state;
    db_cnt_d   = db_cnt;
    hold_cnt_d = hold_cnt;
    rep_cnt_d  = rep_cnt;
    level_d    = btn_level;
    long_d     = long_hold;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;

    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_d  = DB_PRESS;
          db_cnt_d = DB_ONE;
        end
      end

      DB_PRESS: begin
        if (!btn_sync) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DB_ONE;
        end
      end

      // Hold/repeat counters advance only on edges spent in HELD, so a release glitch freezes them.
      HELD: begin
        if (!btn_sync) begin
          state_d  = DB_RELEASE;
          db_cnt_d = DB_ONE;
        end else if (!long_hold) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt_d = HOLD_MAX;
            rep_cnt_d  = '0;
            long_d     = 1'b1;
            repeat_d   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt + HOLD_ONE;
          end
        end else if (rep_cnt == REP_LAST) begin
          rep_cnt_d = '0;
          repeat_d  = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt + REP_ONE;
        end
      end

      DB_RELEASE: begin
        if (btn_sync) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d    = IDLE;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
          level_d    = 1'b0;
          long_d     = 1'b0;
          release_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DB_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable samples required to accept a level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 100000000, cycles after an accepted press before long-hold and the first repeat (1 s).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 25000000, period of auto-repeat pulses while long-held (250 ms).
REQ-004 SHALL accept only parameter values of 2 or more; counter widths SHALL be $clog2 of the largest count held, with no truncation.
REQ-005 SHALL have port clk, input, 1, single system clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port btn_sync, input, 1, active-high button level, already synchronized to clk by the upstream two-flop synchronizer stage.
REQ-008 SHALL have port btn_level, output, 1, debounced button level.
REQ-009 SHALL have port press_pulse, output, 1, one-cycle strobe on an accepted press.
REQ-010 SHALL have port release_pulse, output, 1, one-cycle strobe on an accepted release.
REQ-011 SHALL have port repeat_pulse, output, 1, one-cycle auto-repeat strobe while long-held.
REQ-012 SHALL have port long_hold, output, 1, level indicating the press has lasted at least HOLD_CYCLES.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, DB_PRESS, HELD, DB_RELEASE. All outputs SHALL be registered.
REQ-014 IDLE: btn_level=0. btn_sync=1 sampled -> DB_PRESS with debounce count=1.
REQ-015 DB_PRESS: each further edge with btn_sync=1 increments the count. Any edge with btn_sync=0 -> IDLE, count cleared, no output activity.
REQ-016 DB_PRESS: at the DEBOUNCE_CYCLES-th consecutive high sample -> HELD. btn_level rises and press_pulse is 1 for exactly the following cycle.
REQ-017 HELD: the hold counter starts at 0 in the press_pulse cycle and increments every cycle.
REQ-018 HELD: when the hold counter reaches HOLD_CYCLES, long_hold rises and repeat_pulse is 1 for one cycle.
REQ-019 HELD, after long_hold: a further one-cycle repeat_pulse SHALL occur every REPEAT_CYCLES cycles. The repeat counter wraps and the hold counter saturates, so neither overflows.
REQ-020 HELD: btn_sync=0 sampled -> DB_RELEASE with debounce count=1. The hold and repeat counters freeze and no repeat_pulse is issued in DB_RELEASE.
REQ-021 DB_RELEASE: btn_sync=1 sampled before the count completes -> return to HELD. Frozen counters resume; btn_level and long_hold are unchanged and press_pulse does not fire.
REQ-022 DB_RELEASE: at the DEBOUNCE_CYCLES-th consecutive low sample -> IDLE. btn_level and long_hold fall and release_pulse is 1 for exactly the following cycle; the hold and repeat counters clear.
REQ-023 press_pulse, release_pulse and repeat_pulse SHALL never be high in the same cycle, and none SHALL exceed one cycle per event.
REQ-024 The latency from the first high sample to btn_level=1 SHALL be exactly DEBOUNCE_CYCLES edges, with no extra pipeline stage.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, clear all counters, and drive btn_level, press_pulse, release_pulse, repeat_pulse and long_hold to 0, in any state.
REQ-026 A reset asserted mid-press SHALL produce no release_pulse. After deassertion, a still-held button SHALL be re-debounced from IDLE and produce one press_pulse after DEBOUNCE_CYCLES samples.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-027 Clean press: btn_sync high from edge 1 -> btn_level=1 and press_pulse=1 after edge 4; press_pulse=0 after edge 5.
REQ-028 Bounce: btn_sync pattern 1,1,1,0,1,1,1,1 -> exactly one press_pulse, after the fourth consecutive high (edge 8); no pulse earlier.
REQ-029 Long hold: press held 20 cycles past press_pulse -> long_hold rises and repeat_pulse fires at hold count 10, with repeats at 13, 16 and 19.
REQ-030 Release glitch: while HELD, btn_sync 0,0,1 then held -> no release_pulse and btn_level stays 1. A later 4 lows -> release_pulse once and btn_level=0.
REQ-031 Reset mid-hold: rst_n=0 for 2 cycles while long_hold=1 -> all outputs 0 immediately (asynchronously, not at the next clk edge). With btn_sync held high, press_pulse fires again 4 edges after release of reset.
